// File: rtl/uart_hs_bridge_if.sv
// Bundles the host byte streams, the uart_hs side-band and the FIFO status of uart_hs_bridge.
// slave = bridge side, master = host/uart_hs environment side.
interface uart_hs_bridge_if #(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              tx_in_valid;
  logic [7:0]        tx_in_data;
  logic              tx_in_ready;
  logic              uart_send;
  logic [7:0]        uart_data_in;
  logic              uart_rec;
  logic [7:0]        uart_data_out;
  logic              rx_out_valid;
  logic [7:0]        rx_out_data;
  logic              rx_out_ready;
  logic              rx_overflow;
  logic              rx_ovf_clr;
  logic [ADDR_W:0]   tx_level;
  logic [ADDR_W:0]   rx_level;

  modport slave (
    input  tx_in_valid, tx_in_data, uart_rec, uart_data_out, rx_out_ready, rx_ovf_clr,
    output tx_in_ready, uart_send, uart_data_in, rx_out_valid, rx_out_data, rx_overflow,
           tx_level, rx_level
  );

  modport master (
    output tx_in_valid, tx_in_data, uart_rec, uart_data_out, rx_out_ready, rx_ovf_clr,
    input  tx_in_ready, uart_send, uart_data_in, rx_out_valid, rx_out_data, rx_overflow,
           tx_level, rx_level
  );
endinterface

// File: rtl/uart_hs_bridge.sv
// Stream-to-uart_hs bridge: paced TX FIFO feeding uart_send/uart_data_in, RX FIFO fed by uart_rec edges.
// Optional UART_HS_BRIDGE_LOOPBACK_EN adds a loopback input routing TX bytes straight into the RX FIFO.
module uart_hs_bridge #(
  parameter int DEPTH        = 16,
  parameter int SEND_HIGH    = 4,
  parameter int FRAME_CYCLES = 256
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
`ifdef UART_HS_BRIDGE_LOOPBACK_EN
  input  logic            loopback,
`endif
  uart_hs_bridge_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(FRAME_CYCLES + 1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tx_state_t;

  logic w_lb_on;
`ifdef UART_HS_BRIDGE_LOOPBACK_EN
  assign w_lb_on = loopback;
`else
  assign w_lb_on = 1'b0;
`endif

  // ---------------- TX FIFO ----------------
  logic [7:0]        r_tx_mem [DEPTH];
  logic [ADDR_W-1:0] r_tx_wptr, r_tx_rptr;
  logic [ADDR_W:0]   r_tx_level, w_tx_level_nxt;
  logic              r_tx_ready;
  logic              w_tx_push, w_tx_pop;

  assign w_tx_push = bus.tx_in_valid & r_tx_ready;

  always_comb begin
    w_tx_level_nxt = r_tx_level;
    unique case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_level_nxt = r_tx_level + LVL_ONE;
      2'b01:   w_tx_level_nxt = r_tx_level - LVL_ONE;
      default: w_tx_level_nxt = r_tx_level;
    endcase
  end

  // NOTE: storage arrays carry no reset; pointers and levels alone define validity, and
  // leaving the RAM unreset lets it map onto plain memory cells.
  always_ff @(posedge sys_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.tx_in_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_level <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
      r_tx_level <= w_tx_level_nxt;
      r_tx_ready <= (w_tx_level_nxt != LVL_FULL);
    end
  end

  // ---------------- TX pacing FSM ----------------
  tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_send, w_send_nxt;
  logic [7:0]       r_data, w_data_nxt;

  // NOTE: every combinational output gets a default before the case so no path leaves a
  // latch behind.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_send_nxt  = r_send;
    w_data_nxt  = r_data;
    w_tx_pop    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_tx_level != '0) begin
          w_tx_pop    = 1'b1;
          w_data_nxt  = r_tx_mem[r_tx_rptr];
          w_send_nxt  = ~w_lb_on;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == CNT_W'(SEND_HIGH)) begin
          w_send_nxt  = 1'b0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == CNT_W'(FRAME_CYCLES)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_send_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_send  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_send  <= w_send_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // ---------------- RX capture and FIFO ----------------
  logic [7:0]        r_rx_mem [DEPTH];
  logic [ADDR_W-1:0] r_rx_wptr, r_rx_rptr;
  logic [ADDR_W:0]   r_rx_level, w_rx_level_nxt;
  logic              r_rec_d, r_ovf;
  logic              w_rx_req, w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]        w_rx_din;

  // Loopback bytes and line edges are mutually exclusive, so one write port suffices.
  assign w_rx_req   = (bus.uart_rec & ~r_rec_d & ~w_lb_on) | (w_tx_pop & w_lb_on);
  assign w_rx_din   = w_lb_on ? r_tx_mem[r_tx_rptr] : bus.uart_data_out;
  assign w_rx_full  = (r_rx_level == LVL_FULL);
  assign w_rx_empty = (r_rx_level == '0);
  assign w_rx_pop   = ~w_rx_empty & bus.rx_out_ready;
  assign w_rx_push  = w_rx_req & (~w_rx_full | w_rx_pop);

  always_comb begin
    w_rx_level_nxt = r_rx_level;
    unique case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_level_nxt = r_rx_level + LVL_ONE;
      2'b01:   w_rx_level_nxt = r_rx_level - LVL_ONE;
      default: w_rx_level_nxt = r_rx_level;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= w_rx_din;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_level <= '0;
      r_rec_d    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rec_d <= bus.uart_rec;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
      r_rx_level <= w_rx_level_nxt;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_rx_req & ~w_rx_push) r_ovf <= 1'b1;
      else if (bus.rx_ovf_clr)   r_ovf <= 1'b0;
    end
  end

  assign bus.tx_in_ready  = r_tx_ready;
  assign bus.uart_send    = r_send;
  assign bus.uart_data_in = r_data;
  assign bus.rx_out_valid = ~w_rx_empty;
  assign bus.rx_out_data  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
  assign bus.rx_overflow  = r_ovf;
  assign bus.tx_level     = r_tx_level;
  assign bus.rx_level     = r_rx_level;
endmodule

// File: tb/tb_uart_hs_bridge.sv
// Directed self-checking bench for uart_hs_bridge: reset, TX pacing, TX back-pressure, RX capture,
// RX overflow/clear and full-level push+pop; loopback when UART_HS_BRIDGE_LOOPBACK_EN is defined.
module tb_uart_hs_bridge;
  logic sys_clk;
  logic sys_rst_n;
`ifdef UART_HS_BRIDGE_LOOPBACK_EN
  logic loopback;
`endif

  uart_hs_bridge_if #(.DEPTH(16)) bus ();

  uart_hs_bridge #(.DEPTH(16), .SEND_HIGH(4), .FRAME_CYCLES(256)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
`ifdef UART_HS_BRIDGE_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart_send monitor: rise cycle, latched byte and high width per frame
  int         cyc = 0;
  logic       prev_send = 1'b0;
  int         hi_cnt = 0;
  int         q_rise[$];
  logic [7:0] q_dat[$];
  int         q_wid[$];

  always @(negedge sys_clk) begin
    if (bus.uart_send && !prev_send) begin
      q_rise.push_back(cyc);
      q_dat.push_back(bus.uart_data_in);
      hi_cnt = 0;
    end
    if (bus.uart_send) hi_cnt++;
    else if (prev_send) q_wid.push_back(hi_cnt);
    prev_send = bus.uart_send;
    cyc++;
  end

  task automatic clear_mon();
    q_rise.delete();
    q_dat.delete();
    q_wid.delete();
  endtask

  task automatic rec_byte(input logic [7:0] b, input logic rdy, input logic clr);
    bus.uart_data_out = b;
    bus.uart_rec      = 1'b1;
    bus.rx_out_ready  = rdy;
    bus.rx_ovf_clr    = clr;
    @(negedge sys_clk);
    bus.rx_out_ready  = 1'b0;
    bus.rx_ovf_clr    = 1'b0;
    repeat (3) @(negedge sys_clk);
    bus.uart_rec      = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    int i, guard, maxlvl, bad;
    logic saw_full, accepted;

    bus.tx_in_valid   = 1'b0;
    bus.tx_in_data    = 8'h00;
    bus.uart_rec      = 1'b0;
    bus.uart_data_out = 8'h00;
    bus.rx_out_ready  = 1'b0;
    bus.rx_ovf_clr    = 1'b0;
`ifdef UART_HS_BRIDGE_LOOPBACK_EN
    loopback          = 1'b0;
`endif
    sys_rst_n         = 1'b0;

    // 1. reset state
    repeat (3) @(negedge sys_clk);
    check("rst_tx_ready",  32'(bus.tx_in_ready),  32'd1);
    check("rst_send",      32'(bus.uart_send),    32'd0);
    check("rst_data_in",   32'(bus.uart_data_in), 32'h00);
    check("rst_rx_valid",  32'(bus.rx_out_valid), 32'd0);
    check("rst_rx_data",   32'(bus.rx_out_data),  32'h00);
    check("rst_ovf",       32'(bus.rx_overflow),  32'd0);
    check("rst_tx_level",  32'(bus.tx_level),     32'd0);
    check("rst_rx_level",  32'(bus.rx_level),     32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // 2. two back-to-back bytes: rises 257 cycles apart, 4 cycles high each
    clear_mon();
    bus.tx_in_valid = 1'b1;
    bus.tx_in_data  = 8'h55;
    @(negedge sys_clk);
    bus.tx_in_data  = 8'hA3;
    @(negedge sys_clk);
    bus.tx_in_valid = 1'b0;
    guard = 0;
    while (q_wid.size() < 2 && guard < 800) begin
      @(negedge sys_clk);
      guard++;
    end
    check("t2_frames", 32'(q_wid.size()), 32'd2);
    if (q_wid.size() >= 2) begin
      check("t2_byte0",   32'(q_dat[0]), 32'h55);
      check("t2_byte1",   32'(q_dat[1]), 32'hA3);
      check("t2_spacing", 32'(q_rise[1] - q_rise[0]), 32'd257);
      check("t2_width0",  32'(q_wid[0]), 32'd4);
      check("t2_width1",  32'(q_wid[1]), 32'd4);
    end
    check("t2_data_hold", 32'(bus.uart_data_in), 32'hA3);
    check("t2_tx_level",  32'(bus.tx_level),     32'd0);

    // 3. 17 bytes, no host stall: FIFO hits 16, ready drops, all sent in order
    clear_mon();
    i = 0; guard = 0; maxlvl = 0; bad = 0; saw_full = 1'b0;
    while (i < 17 && guard < 2000) begin
      bus.tx_in_valid = 1'b1;
      bus.tx_in_data  = 8'(16 + i);
      accepted = bus.tx_in_ready;
      @(negedge sys_clk);
      if (accepted) i++;
      if (int'(bus.tx_level) > maxlvl) maxlvl = int'(bus.tx_level);
      if (!bus.tx_in_ready) saw_full = 1'b1;
      if (bus.tx_in_ready != (bus.tx_level != 5'd16)) bad++;
      guard++;
    end
    bus.tx_in_valid = 1'b0;
    check("t3_pushed",      32'(i),        32'd17);
    check("t3_max_level",   32'(maxlvl),   32'd16);
    check("t3_saw_full",    32'(saw_full), 32'd1);
    check("t3_ready_vs_lvl", 32'(bad),     32'd0);
    guard = 0;
    while (q_dat.size() < 17 && guard < 6000) begin
      @(negedge sys_clk);
      guard++;
    end
    check("t3_sent", 32'(q_dat.size()), 32'd17);
    for (int k = 0; k < 17; k++) begin
      if (k < q_dat.size()) check($sformatf("t3_byte%0d", k), 32'(q_dat[k]), 32'(16 + k));
    end

    // 4. one long uart_rec pulse -> exactly one entry
    bus.uart_data_out = 8'h3C;
    bus.uart_rec      = 1'b1;
    repeat (14) @(negedge sys_clk);
    bus.uart_rec      = 1'b0;
    @(negedge sys_clk);
    check("t4_rx_level", 32'(bus.rx_level),     32'd1);
    check("t4_rx_valid", 32'(bus.rx_out_valid), 32'd1);
    check("t4_rx_data",  32'(bus.rx_out_data),  32'h3C);
    bus.rx_out_ready = 1'b1;
    @(negedge sys_clk);
    bus.rx_out_ready = 1'b0;
    check("t4_level_after_pop", 32'(bus.rx_level),    32'd0);
    check("t4_data_empty",      32'(bus.rx_out_data), 32'h00);

    // 5. fill RX, overflow (set beats clear), clear, push+pop at full, drain
    for (int k = 0; k < 16; k++) rec_byte(8'(8'h80 + k), 1'b0, 1'b0);
    check("t5_full_level", 32'(bus.rx_level),    32'd16);
    check("t5_no_ovf",     32'(bus.rx_overflow), 32'd0);
    check("t5_head",       32'(bus.rx_out_data), 32'h80);
    rec_byte(8'hEE, 1'b0, 1'b1);
    check("t5_ovf_set",    32'(bus.rx_overflow), 32'd1);
    check("t5_ovf_level",  32'(bus.rx_level),    32'd16);
    bus.rx_ovf_clr = 1'b1;
    @(negedge sys_clk);
    bus.rx_ovf_clr = 1'b0;
    check("t5_ovf_clr",    32'(bus.rx_overflow), 32'd0);
    rec_byte(8'h90, 1'b1, 1'b0);
    check("t5_pp_level",   32'(bus.rx_level),    32'd16);
    check("t5_pp_no_ovf",  32'(bus.rx_overflow), 32'd0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t5_drain%0d", k), 32'(bus.rx_out_data), 32'(8'h81 + k));
      bus.rx_out_ready = 1'b1;
      @(negedge sys_clk);
      bus.rx_out_ready = 1'b0;
    end
    check("t5_drained_level", 32'(bus.rx_level),     32'd0);
    check("t5_drained_valid", 32'(bus.rx_out_valid), 32'd0);

`ifdef UART_HS_BRIDGE_LOOPBACK_EN
    // 6. loopback: bytes appear on the RX side 257 cycles apart, uart_send stays low
    begin
      int         lb_t[$];
      logic [7:0] lb_d[$];
      repeat (300) @(negedge sys_clk);
      clear_mon();
      loopback = 1'b1;
      bus.tx_in_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        bus.tx_in_data = 8'(k);
        @(negedge sys_clk);
      end
      bus.tx_in_valid = 1'b0;
      guard = 0;
      while (lb_d.size() < 4 && guard < 1500) begin
        if (bus.rx_out_valid) begin
          lb_d.push_back(bus.rx_out_data);
          lb_t.push_back(cyc);
        end
        bus.rx_out_ready = bus.rx_out_valid;
        @(negedge sys_clk);
        guard++;
      end
      bus.rx_out_ready = 1'b0;
      check("t6_count",     32'(lb_d.size()),   32'd4);
      check("t6_no_send",   32'(q_rise.size()), 32'd0);
      for (int k = 0; k < 4; k++) begin
        if (k < lb_d.size()) check($sformatf("t6_byte%0d", k), 32'(lb_d[k]), 32'(k + 1));
        if (k > 0 && k < lb_t.size())
          check($sformatf("t6_gap%0d", k), 32'(lb_t[k] - lb_t[k-1]), 32'd257);
      end
      loopback = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
